csa_slice_sequencer: RTL
========================

// Module: csa_slice_sequencer
// PURPOSE
//  Multi-cycle controller that computes a WIDTH-bit add using one SLICE-bit carry-select slice, one slice per clock.
//  Slice 0 (LSBs) is processed first. A registered carry links each slice to the next.
//  Operands enter and results leave on valid/ready handshakes.
//  It sits between an operand producer and a result consumer, where a full-width adder is too large or too slow.
// PARAMETERS
//  WIDTH  32  operand/result width; must be an integer multiple of SLICE
//  SLICE  4   bits added per cycle; NSLICE = WIDTH/SLICE (NSLICE >= 2)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous reset, active-low
//  in_valid   in   1      operand set valid
//  in_ready   out  1      block can accept operands
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in to slice 0
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_sum    out  WIDTH  registered sum
//  out_cout   out  1      carry-out of the top slice
//  busy       out  1      high in RUN or DONE
//  out_ovf    out  1      signed overflow; exists only with CSA_SEQ_OVF_EN
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - state=IDLE, slice index=0, carry reg=0, operand regs=0
//   - out_sum=0, out_cout=0, out_valid=0, busy=0, out_ovf=0
//   - in_ready=1 once rst_n is released
//  FSM states IDLE, RUN, DONE:
//   - IDLE: in_ready=1.
//     On in_valid&in_ready: latch in_a, in_b; load in_cin into the carry reg; index=0; go to RUN.
//   - RUN: in_ready=0. Each cycle the slice adds a[idx], b[idx] and the carry reg:
//     two SLICE-bit sums (cin=0 and cin=1) are precomputed, then the carry reg selects one.
//     The selected slice is written into out_sum[idx*SLICE +: SLICE]; the carry reg takes that slice's carry-out; idx++.
//     After the slice at idx=NSLICE-1 is written: out_cout=final carry, go to DONE.
//   - DONE: out_valid=1.
//     out_sum, out_cout and out_ovf hold stable while out_ready=0.
//     On out_valid&out_ready: out_valid=0 and go to IDLE on that edge.
//  Latency: out_valid rises NSLICE cycles after the accepting edge.
//   - With WIDTH=32, SLICE=4, out_valid rises 8 cycles after acceptance.
//  Throughput: one op per NSLICE+2 cycles minimum; no overlap of operations.
//  Handshake rules:
//   - in_valid is ignored while in_ready=0.
//   - out_ready is ignored while out_valid=0.
//   - A new accept can occur the first cycle back in IDLE.
//  Arithmetic: unsigned modulo 2^WIDTH; {out_cout,out_sum} = in_a+in_b+in_cin.
//  out_sum while out_valid=0:
//   - During RUN it shows partially updated slices.
//   - In IDLE it holds the last result.
//   - Consumers use out_sum only when out_valid=1.
//  Boundary conditions:
//   - Full carry propagation (all-ones + 1) needs no extra cycle.
//   - The index wraps to 0 only on a new accept.
//   - Reset mid-RUN or mid-DONE aborts the op, discards the result and applies the reset values.
// CONFIGURATION
//  CSA_SEQ_OVF_EN defined:
//   - out_ovf is present.
//   - out_ovf = carry into MSB XOR carry out of MSB, captured with the top slice.
//   - out_ovf is valid with out_valid and held in DONE.
//  CSA_SEQ_OVF_EN undefined: no out_ovf port and no related logic.
// TESTING (WIDTH=32, SLICE=4)
//  1. a=0x00000006, b=0x00000006, cin=0 -> sum=0x0000000C, cout=0; out_valid exactly 8 cycles after accept.
//  2. a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1 (carry ripples through all 8 slices).
//  3. a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0; out_ovf=1 with CSA_SEQ_OVF_EN.
//  4. Backpressure: hold out_ready=0 for 5 cycles in DONE, pulse in_valid -> out_sum, out_cout stable; in_ready=0; pulse ignored.
//  5. Reset asserted after 3 RUN cycles -> out_valid=0, out_sum=0 immediately; next op a=0x0000000E, b=0x00000007 -> sum=0x00000015.
//  6. Back-to-back, out_ready=1 and in_valid=1 held: ops (0x12345678+0x11111111), then (0xFFFFFFF0+0x10, cin=1) -> 0x23456789 cout=0; then 0x00000001 cout=1; in_ready=1 the cycle after each result handshake.

Source files
------------

// File: rtl/csa_slice_sequencer.sv
// Purpose : WIDTH-bit add done one SLICE-bit carry-select slice per clock, LSB slice first.
// Latency : out_valid rises NSLICE cycles after the accepting edge; one op in flight at a time.
// Backpr. : in_ready only in IDLE; result, carry and overflow hold in DONE until out_ready.
// Ports   : clk, rst_n (async, active-low); in_valid/in_ready/in_a/in_b/in_cin operand handshake;
//           out_valid/out_ready/out_sum/out_cout result handshake; busy (RUN or DONE);
//           out_ovf signed overflow, present only when CSA_SEQ_OVF_EN is defined.
module csa_slice_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
`ifdef CSA_SEQ_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;

  logic [SLICE-1:0] a_sl, b_sl;
  logic [SLICE:0]   sum0, sum1, sel;
  logic             last;
  logic             accept;

  // Carry-select slice: both carry-in outcomes are formed up front, the
  // registered carry only steers the final mux.
  always_comb begin
    a_sl = a_q[idx_q*SLICE +: SLICE];
    b_sl = b_q[idx_q*SLICE +: SLICE];
    sum0 = {1'b0, a_sl} + {1'b0, b_sl};
    sum1 = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE+1)'(1);
    sel  = carry_q ? sum1 : sum0;
    last = (idx_q == LAST_IDX);
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = rst_n;
        accept   = in_valid && rst_n;
        if (accept) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
`ifdef CSA_SEQ_OVF_EN
      out_ovf  <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= in_a;
      b_q     <= in_b;
      carry_q <= in_cin;
      idx_q   <= '0;
    end else if (state == S_RUN) begin
      out_sum[idx_q*SLICE +: SLICE] <= sel[SLICE-1:0];
      carry_q <= sel[SLICE];
      if (last) begin
        // Index parks on the top slice; it only returns to 0 on the next accept.
        out_cout <= sel[SLICE];
`ifdef CSA_SEQ_OVF_EN
        // Same-sign operands giving an opposite-sign result is exactly
        // carry-into-MSB XOR carry-out-of-MSB.
        out_ovf  <= (a_sl[SLICE-1] == b_sl[SLICE-1]) && (sel[SLICE-1] != a_sl[SLICE-1]);
`endif
      end else begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

endmodule
